// File: rtl/fll_lock_seq.sv
// Lock sequencer for the frequency-rebound loop: resets the rebound block, waits for settle,
// qualifies a steady code and freezes it. Define FLLSEQ_RELOCK_EN to re-track on drift in LOCKED.
module fll_lock_seq #(
  parameter int W           = 8,
  parameter int RST_CYC     = 4,
  parameter int SETTLE_CYC  = 64,
  parameter int LOCK_CNT    = 32,
  parameter int TOL         = 1,
  parameter int TIMEOUT_CYC = 4096,
  parameter int UNLOCK_CNT  = 8
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] fcode_syn,
  output logic         rb_rstb,
  output logic [W-1:0] code_out,
  output logic         locked,
  output logic         fail,
  output logic         busy,
  output logic [2:0]   state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RESET  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_TRACK  = 3'd3;
  localparam logic [2:0] S_LOCKED = 3'd4;
  localparam logic [2:0] S_FAIL   = 3'd5;

  localparam logic [15:0]  RST_LAST     = 16'(RST_CYC - 1);
  localparam logic [15:0]  SETTLE_LAST  = 16'(SETTLE_CYC - 1);
  localparam logic [15:0]  LOCK_LAST    = 16'(LOCK_CNT - 1);
  localparam logic [15:0]  TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [W:0]   TOL_W        = (W+1)'(TOL);
  localparam logic [W-1:0] CODE_RST     = W'(8);

  // Magnitude of the difference, widened by one bit so it can never wrap.
  function automatic logic [W:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a >= b) abs_diff = {1'b0, a} - {1'b0, b};
    else        abs_diff = {1'b0, b} - {1'b0, a};
  endfunction

  logic [2:0]   state_q, state_d;
  logic [15:0]  timer_q, timer_d;
  logic [15:0]  stab_q, stab_d;
  logic [W-1:0] prev_q, prev_d;
  logic [W-1:0] code_q, code_d;
  logic         rb_rstb_q, locked_q, fail_q, busy_q;
  logic         trk_stable;
`ifdef FLLSEQ_RELOCK_EN
  localparam logic [15:0] UNLOCK_LAST = 16'(UNLOCK_CNT - 1);
  logic [15:0] drift_q, drift_d;
  logic        drift_out;
`endif

  assign trk_stable = (abs_diff(fcode_syn, prev_q) <= TOL_W);
`ifdef FLLSEQ_RELOCK_EN
  assign drift_out  = (abs_diff(fcode_syn, code_q) > TOL_W);
`endif

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    prev_d  = prev_q;
    code_d  = code_q;
`ifdef FLLSEQ_RELOCK_EN
    drift_d = '0;
`endif
    case (state_q)
      S_IDLE:   if (start) state_d = S_RESET;
      S_RESET:  if (timer_q == RST_LAST) state_d = S_SETTLE;
      S_SETTLE: if (timer_q == SETTLE_LAST) begin
        state_d = S_TRACK;
        stab_d  = '0;
        prev_d  = fcode_syn;
      end
      S_TRACK: begin
        prev_d = fcode_syn;
        stab_d = trk_stable ? stab_q + 16'd1 : 16'd0;
        // Lock takes precedence over a timeout landing on the same cycle.
        if (trk_stable && stab_q == LOCK_LAST) begin
          state_d = S_LOCKED;
          code_d  = fcode_syn;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d = S_FAIL;
        end
      end
      S_LOCKED: begin
`ifdef FLLSEQ_RELOCK_EN
        drift_d = drift_out ? drift_q + 16'd1 : 16'd0;
        if (drift_out && drift_q == UNLOCK_LAST) begin
          state_d = S_TRACK;
          stab_d  = '0;
          prev_d  = fcode_syn;
          drift_d = '0;
        end
`endif
        if (start) state_d = S_RESET;
      end
      S_FAIL:   if (start) state_d = S_RESET;
      default:  state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
`ifdef FLLSEQ_RELOCK_EN
    if (state_d != S_LOCKED) drift_d = '0;
`endif
    timer_d = (state_d != state_q) ? 16'd0 : timer_q + 16'd1;
  end

  // Outputs are decoded from the next state so they switch on the transition edge itself.
  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      stab_q    <= '0;
      code_q    <= CODE_RST;
      rb_rstb_q <= 1'b0;
      locked_q  <= 1'b0;
      fail_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef FLLSEQ_RELOCK_EN
      drift_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      stab_q    <= stab_d;
      code_q    <= code_d;
      rb_rstb_q <= !(state_d == S_IDLE || state_d == S_RESET);
      locked_q  <= (state_d == S_LOCKED);
      fail_q    <= (state_d == S_FAIL);
      busy_q    <= (state_d == S_RESET || state_d == S_SETTLE || state_d == S_TRACK);
`ifdef FLLSEQ_RELOCK_EN
      drift_q   <= drift_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    prev_q <= prev_d;
  end

  assign state    = state_q;
  assign rb_rstb  = rb_rstb_q;
  assign code_out = code_q;
  assign locked   = locked_q;
  assign fail     = fail_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_fll_lock_seq.sv
// Scoreboard bench for fll_lock_seq at default parameters; honours FLLSEQ_RELOCK_EN like the RTL.
module tb_fll_lock_seq;

  logic       clk = 1'b0;
  logic       rstb, start, abort;
  logic [7:0] fcode_syn;
  logic       rb_rstb, locked, fail, busy;
  logic [7:0] code_out;
  logic [2:0] state;

  fll_lock_seq dut (
    .clk(clk), .rstb(rstb), .start(start), .abort(abort), .fcode_syn(fcode_syn),
    .rb_rstb(rb_rstb), .code_out(code_out), .locked(locked), .fail(fail),
    .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] code;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstb = 1'b1; start = 1'b0; abort = 1'b0;
    tick(); tick();
    rstb = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (state !== 3'd0)    begin n_mis++; $display("FAIL reset_state got %0d want 0", state); end
    n_cmp++; if (rb_rstb !== 1'b0)  begin n_mis++; $display("FAIL reset_rb_rstb got %b want 0", rb_rstb); end
    n_cmp++; if (code_out !== 8'd8) begin n_mis++; $display("FAIL reset_code got %0d want 8", code_out); end
    n_cmp++; if ({locked, fail, busy} !== 3'b000) begin n_mis++; $display("FAIL reset_flags got %b want 000", {locked, fail, busy}); end
  endtask

  task automatic test_lock_hold();
    int t0, n;
    exp_t e;
    do_reset();
    fcode_syn = 8'd5;
    start = 1'b1; t0 = cyc;
    e.cyc = t0 + 101; e.code = 8'd5; sb.push_back(e);
    tick(); start = 1'b0;
    n_cmp++; if (state !== 3'd1) begin n_mis++; $display("FAIL hold_reset_state got %0d want 1", state); end
    n_cmp++; if (busy !== 1'b1)  begin n_mis++; $display("FAIL hold_busy got %b want 1", busy); end
    n = 0;
    while (rb_rstb === 1'b0 && n < 100) begin n++; tick(); end
    n_cmp++; if (n != 4) begin n_mis++; $display("FAIL hold_rb_low_cycles got %0d want 4", n); end
    while (locked !== 1'b1 && cyc < t0 + 300) tick();
    e = sb.pop_front();
    n_cmp++; if (cyc != e.cyc)       begin n_mis++; $display("FAIL hold_lock_cycle got %0d want %0d", cyc - t0, e.cyc - t0); end
    n_cmp++; if (code_out !== e.code) begin n_mis++; $display("FAIL hold_code got %0d want %0d", code_out, e.code); end
    n_cmp++; if (state !== 3'd4 || busy !== 1'b0) begin n_mis++; $display("FAIL hold_locked_state got %0d/%b want 4/0", state, busy); end
  endtask

  task automatic test_fail_alt();
    int t0;
    bit saw_lock;
    exp_t e;
    do_reset();
    fcode_syn = 8'd2; saw_lock = 0;
    start = 1'b1; t0 = cyc;
    e.cyc = t0 + 1 + 4 + 64 + 4096; e.code = 8'd8; sb.push_back(e);
    tick(); start = 1'b0;
    while (fail !== 1'b1 && cyc < t0 + 5000) begin
      if (locked === 1'b1) saw_lock = 1;
      fcode_syn = (fcode_syn == 8'd2) ? 8'd6 : 8'd2;
      tick();
    end
    e = sb.pop_front();
    n_cmp++; if (saw_lock !== 1'b0)   begin n_mis++; $display("FAIL alt_never_lock got %b want 0", saw_lock); end
    n_cmp++; if (cyc != e.cyc)        begin n_mis++; $display("FAIL alt_fail_cycle got %0d want %0d", cyc - t0, e.cyc - t0); end
    n_cmp++; if (state !== 3'd5 || busy !== 1'b0 || rb_rstb !== 1'b1) begin n_mis++; $display("FAIL alt_fail_state got %0d/%b/%b want 5/0/1", state, busy, rb_rstb); end
    n_cmp++; if (code_out !== e.code) begin n_mis++; $display("FAIL alt_code_kept got %0d want %0d", code_out, e.code); end
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++; if (state !== 3'd1 || fail !== 1'b0 || rb_rstb !== 1'b0) begin n_mis++; $display("FAIL alt_restart got %0d/%b/%b want 1/0/0", state, fail, rb_rstb); end
  endtask

  // Step lands on the j-th TRACK sample; delay is the expected postponement of lock.
  task automatic test_step(input logic [7:0] to, input int j, input int delay);
    int t0;
    exp_t e;
    do_reset();
    fcode_syn = 8'd4;
    start = 1'b1; t0 = cyc;
    e.cyc = t0 + 101 + delay; e.code = to; sb.push_back(e);
    tick(); start = 1'b0;
    while (locked !== 1'b1 && cyc < t0 + 300) begin
      if (cyc == t0 + 68 + j) fcode_syn = to;
      tick();
    end
    e = sb.pop_front();
    n_cmp++; if (cyc != e.cyc)        begin n_mis++; $display("FAIL step%0d_lock_cycle got %0d want %0d", to, cyc - t0, e.cyc - t0); end
    n_cmp++; if (code_out !== e.code) begin n_mis++; $display("FAIL step%0d_code got %0d want %0d", to, code_out, e.code); end
  endtask

  task automatic test_abort();
    int t0;
    do_reset();
    fcode_syn = 8'd5;
    start = 1'b1; t0 = cyc; tick(); start = 1'b0;
    while (state !== 3'd3 && cyc < t0 + 200) tick();
    n_cmp++; if (state !== 3'd3) begin n_mis++; $display("FAIL abort_reach_track got %0d want 3", state); end
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    n_cmp++; if (state !== 3'd0 || rb_rstb !== 1'b0 || busy !== 1'b0) begin n_mis++; $display("FAIL abort_idle got %0d/%b/%b want 0/0/0", state, rb_rstb, busy); end
    n_cmp++; if (code_out !== 8'd8) begin n_mis++; $display("FAIL abort_code got %0d want 8", code_out); end
    tick(); tick();
    n_cmp++; if (state !== 3'd0) begin n_mis++; $display("FAIL abort_stay_idle got %0d want 0", state); end
  endtask

  task automatic test_rstb_locked();
    int t0;
    do_reset();
    fcode_syn = 8'd5;
    start = 1'b1; t0 = cyc; tick(); start = 1'b0;
    while (locked !== 1'b1 && cyc < t0 + 300) tick();
    n_cmp++; if (locked !== 1'b1 || code_out !== 8'd5) begin n_mis++; $display("FAIL rst_pre_lock got %b/%0d want 1/5", locked, code_out); end
    rstb = 1'b1; tick(); rstb = 1'b0;
    n_cmp++; if (state !== 3'd0 || rb_rstb !== 1'b0) begin n_mis++; $display("FAIL rst_mid_state got %0d/%b want 0/0", state, rb_rstb); end
    n_cmp++; if (code_out !== 8'd8) begin n_mis++; $display("FAIL rst_mid_code got %0d want 8", code_out); end
    n_cmp++; if ({locked, fail, busy} !== 3'b000) begin n_mis++; $display("FAIL rst_mid_flags got %b want 000", {locked, fail, busy}); end
  endtask

  task automatic test_relock();
    int t0, l;
    exp_t e;
    do_reset();
    fcode_syn = 8'd5;
    start = 1'b1; t0 = cyc; tick(); start = 1'b0;
    while (locked !== 1'b1 && cyc < t0 + 300) tick();
    l = cyc;
    n_cmp++; if (l != t0 + 101 || code_out !== 8'd5) begin n_mis++; $display("FAIL drift_pre_lock got %0d/%0d want 101/5", l - t0, code_out); end
    fcode_syn = 8'd8;
`ifdef FLLSEQ_RELOCK_EN
    e.cyc = l + 8; e.code = 8'd5; sb.push_back(e);
    e.cyc = l + 8 + 32; e.code = 8'd8; sb.push_back(e);
    while (locked === 1'b1 && cyc < l + 100) tick();
    e = sb.pop_front();
    n_cmp++; if (cyc != e.cyc)        begin n_mis++; $display("FAIL drift_unlock_cycle got %0d want %0d", cyc - l, e.cyc - l); end
    n_cmp++; if (state !== 3'd3 || rb_rstb !== 1'b1) begin n_mis++; $display("FAIL drift_track got %0d/%b want 3/1", state, rb_rstb); end
    n_cmp++; if (code_out !== e.code) begin n_mis++; $display("FAIL drift_old_code got %0d want %0d", code_out, e.code); end
    while (locked !== 1'b1 && cyc < l + 200) tick();
    e = sb.pop_front();
    n_cmp++; if (cyc != e.cyc)        begin n_mis++; $display("FAIL drift_relock_cycle got %0d want %0d", cyc - l, e.cyc - l); end
    n_cmp++; if (code_out !== e.code) begin n_mis++; $display("FAIL drift_new_code got %0d want %0d", code_out, e.code); end
`else
    e.cyc = l + 50; e.code = 8'd5; sb.push_back(e);
    repeat (50) tick();
    e = sb.pop_front();
    n_cmp++; if (locked !== 1'b1 || state !== 3'd4) begin n_mis++; $display("FAIL drift_stay_locked got %b/%0d want 1/4", locked, state); end
    n_cmp++; if (code_out !== e.code) begin n_mis++; $display("FAIL drift_code_held got %0d want %0d", code_out, e.code); end
`endif
  endtask

  initial begin
    rstb = 1'b1; start = 1'b0; abort = 1'b0; fcode_syn = 8'd0;
    test_reset();
    test_lock_hold();
    test_fail_alt();
    test_step(8'd5, 10, 0);
    test_step(8'd7, 10, 10);
    test_abort();
    test_rstb_locked();
    test_relock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
